// File: rtl/latrn_bank_write_seq.sv
// Write sequencer for a bank of transparent latches: turns valid/ready requests
// into setup/pulse/hold-timed enable (or clear) pulses on a shared data bus.
module latrn_bank_write_seq #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             IN_CLR,
    input  logic [AW-1:0]    IN_ADDR,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic [DEPTH-1:0] E,
    output logic [WIDTH-1:0] D,
    output logic             RN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int MAXC = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    localparam logic [CW-1:0] SETUP_LAST = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [AW:0]   DEPTH_EXT  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             clr_q, clr_d;
    logic             bad_q, bad_d;
    logic [DEPTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             rn_q, rn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             pulse_d;

    // Outputs are decoded from the next state so they are registered yet line up with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        clr_d   = clr_q;
        bad_d   = bad_q;
        d_d     = d_q;

        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    addr_d  = IN_ADDR;
                    clr_d   = IN_CLR;
                    bad_d   = !IN_CLR && ({1'b0, IN_ADDR} >= DEPTH_EXT);
                    cnt_d   = '0;
                    state_d = (SETUP_CYC > 0) ? S_SETUP : S_PULSE;
                    if (!IN_CLR) begin
                        d_d = IN_DATA;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = (HOLD_CYC > 0) ? S_HOLD : S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        pulse_d = (state_d == S_PULSE);
        // An out-of-range write runs the full timing with every enable held low.
        e_d     = (pulse_d && !clr_d && !bad_d) ? (DEPTH'(1) << addr_d) : '0;
        rn_d    = !(pulse_d && clr_d);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        err_d   = done_d && bad_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            clr_q   <= 1'b0;
            bad_q   <= 1'b0;
            e_q     <= '0;
            d_q     <= '0;
            rn_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            clr_q   <= clr_d;
            bad_q   <= bad_d;
            e_q     <= e_d;
            d_q     <= d_d;
            rn_q    <= rn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign IN_READY = (state_q == S_IDLE);
    assign E        = e_q;
    assign D        = d_q;
    assign RN       = rn_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_latrn_bank_write_seq.sv
// Bench for latrn_bank_write_seq: a default instance and a DEPTH=3 zero-setup/hold
// instance, both compared every cycle against a cycle-count timing model.
module tb_latrn_bank_write_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       inVal[2];
    logic       inClr[2];
    logic [1:0] inAddr[2];
    logic [7:0] inData[2];

    logic       rdy0, rdy1, rn0, rn1, busy0, busy1, done0, done1, err0, err1;
    logic [3:0] e0;
    logic [2:0] e1;
    logic [7:0] dq0, dq1;

    int compared   = 0;
    int mismatched = 0;

    int         mK[2];
    logic       mClr[2];
    logic [1:0] mAddr[2];
    logic [7:0] mD[2];
    bit         modelOn = 1'b0;

    always #5 clk = ~clk;

    latrn_bank_write_seq dut0 (
        .CLK(clk), .RST(rst), .IN_VALID(inVal[0]), .IN_READY(rdy0), .IN_CLR(inClr[0]),
        .IN_ADDR(inAddr[0]), .IN_DATA(inData[0]), .E(e0), .D(dq0), .RN(rn0),
        .BUSY(busy0), .DONE(done0), .ERR(err0)
    );

    latrn_bank_write_seq #(
        .WIDTH(8), .DEPTH(3), .AW(2), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)
    ) dut1 (
        .CLK(clk), .RST(rst), .IN_VALID(inVal[1]), .IN_READY(rdy1), .IN_CLR(inClr[1]),
        .IN_ADDR(inAddr[1]), .IN_DATA(inData[1]), .E(e1), .D(dq1), .RN(rn1),
        .BUSY(busy1), .DONE(done1), .ERR(err1)
    );

    function automatic int cfgS(int i);     return (i == 0) ? 1 : 0; endfunction
    function automatic int cfgP(int i);     return (i == 0) ? 2 : 1; endfunction
    function automatic int cfgH(int i);     return (i == 0) ? 1 : 0; endfunction
    function automatic int cfgDepth(int i); return (i == 0) ? 4 : 3; endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic c,
                                 input logic [1:0] a, input logic [7:0] d);
        inVal[idx]  = v;
        inClr[idx]  = c;
        inAddr[idx] = a;
        inData[idx] = d;
    endtask

    // Model: mK counts cycles since the accept edge; the transaction lasts S+P+H+1 cycles.
    always @(posedge clk) begin
        if (rst) begin
            modelOn = 1'b1;
            for (int i = 0; i < 2; i++) begin
                mK[i] = 0;
                mD[i] = 8'h00;
            end
        end else if (modelOn) begin
            for (int i = 0; i < 2; i++) begin
                int len;
                len = cfgS(i) + cfgP(i) + cfgH(i) + 1;
                if (mK[i] == 0) begin
                    if (inVal[i]) begin
                        mK[i]    = 1;
                        mClr[i]  = inClr[i];
                        mAddr[i] = inAddr[i];
                        if (!inClr[i]) mD[i] = inData[i];
                    end
                end else if (mK[i] == len) begin
                    mK[i] = 0;
                end else begin
                    mK[i] = mK[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            for (int i = 0; i < 2; i++) begin
                int k, s, p, len;
                logic pulse, bad, done;
                logic [31:0] expE;
                logic [31:0] oE, oD;
                logic oRdy, oRn, oBusy, oDone, oErr;
                k     = mK[i];
                s     = cfgS(i);
                p     = cfgP(i);
                len   = s + p + cfgH(i) + 1;
                pulse = (k >= s + 1) && (k <= s + p);
                done  = (k == len);
                bad   = !mClr[i] && (int'(mAddr[i]) >= cfgDepth(i));
                expE  = (pulse && !mClr[i] && !bad) ? (32'd1 << mAddr[i]) : 32'd0;
                if (i == 0) begin
                    oE = {28'd0, e0}; oD = {24'd0, dq0}; oRdy = rdy0; oRn = rn0;
                    oBusy = busy0; oDone = done0; oErr = err0;
                end else begin
                    oE = {29'd0, e1}; oD = {24'd0, dq1}; oRdy = rdy1; oRn = rn1;
                    oBusy = busy1; oDone = done1; oErr = err1;
                end
                checkOutput($sformatf("dut%0d E", i), oE, expE);
                checkOutput($sformatf("dut%0d D", i), oD, {24'd0, mD[i]});
                checkOutput($sformatf("dut%0d RN", i), {31'd0, oRn}, {31'd0, !(pulse && mClr[i])});
                checkOutput($sformatf("dut%0d READY", i), {31'd0, oRdy}, {31'd0, k == 0});
                checkOutput($sformatf("dut%0d BUSY", i), {31'd0, oBusy}, {31'd0, k != 0});
                checkOutput($sformatf("dut%0d DONE", i), {31'd0, oDone}, {31'd0, done});
                checkOutput($sformatf("dut%0d ERR", i), {31'd0, oErr}, {31'd0, done && bad});
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Default write to word 2, then a clear that must not touch D.
        applyStimulus(0, 1'b1, 1'b0, 2'd2, 8'hA5);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (8) @(negedge clk);
        applyStimulus(0, 1'b1, 1'b1, 2'd1, 8'h3C);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (8) @(negedge clk);

        // Out-of-range write on the DEPTH=3 instance.
        applyStimulus(1, 1'b1, 1'b0, 2'd3, 8'h77);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (4) @(negedge clk);

        // IN_VALID held high for four back-to-back writes.
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1, 1'b1, 1'b0, 2'($urandom_range(0, 2)), 8'($urandom));
            @(negedge clk);
        end
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (4) @(negedge clk);

        // Reset lands while word 0 is being pulsed, then a normal write follows.
        applyStimulus(0, 1'b1, 1'b0, 2'd0, 8'h5A);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 2'd1, 8'hC3);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (8) @(negedge clk);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                applyStimulus(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                              2'($urandom), 8'($urandom));
            end
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
